// File: rtl/aes_uart_pkg.sv
// Shared constants and FSM encoding for the AES-256 UART host link.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_uart_pkg;
  localparam int NUM_BYTES_TX_FRAME = 48;
  localparam int NUM_KEY_BYTES      = 32;
  localparam int NUM_RESP_BYTES     = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_SEND_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } host_state_t;
endpackage

// File: rtl/aes_uart_byte_mux.sv
// Selects the outgoing frame byte: key bytes 0..31, then text bytes 0..15.
// Latency: combinational.
// Backpressure: none; the caller holds sel_i steady while the byte is in flight.
module aes_uart_byte_mux
  import aes_uart_pkg::*;
(
  input  logic [255:0] key_i,
  input  logic [127:0] text_i,
  input  logic [5:0]   sel_i,
  output logic [7:0]   byte_o
);
  // sel 0..31 addresses the key; 32..47 share low bits 0..15 with the text index.
  always_comb begin
    byte_o = 8'h00;
    if (sel_i < 6'(NUM_KEY_BYTES)) begin
      byte_o = key_i[8*sel_i[4:0] +: 8];
    end else begin
      byte_o = text_i[8*sel_i[3:0] +: 8];
    end
  end
endmodule

// File: rtl/serial_rx.sv
// UART byte receiver: 8N1, LSB first, samples mid-bit after a 2-flop synchronizer.
// Latency: new_data pulses near the middle of the stop bit.
// Backpressure: none; each byte is presented for exactly one cycle.
module serial_rx #(
  parameter int CLK_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data
);
  localparam int CW = $clog2(CLK_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLK_PER_BIT / 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

  rx_state_t     st_q;
  logic [CW-1:0] ctr_q;
  logic [2:0]    bit_q;
  logic [7:0]    data_q;
  logic          new_data_q;
  logic          rx_meta_q;
  logic          rx_sync_q;

  // Synchronize the line, find the start bit centre, then sample every bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= S_IDLE;
      ctr_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      new_data_q <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      new_data_q <= 1'b0;
      case (st_q)
        S_IDLE: begin
          ctr_q <= '0;
          if (!rx_sync_q) st_q <= S_START;
        end
        S_START: begin
          if (ctr_q == BIT_HALF) begin
            ctr_q <= '0;
            bit_q <= '0;
            st_q  <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        S_DATA: begin
          if (ctr_q == BIT_LAST) begin
            ctr_q  <= '0;
            data_q <= {rx_sync_q, data_q[7:1]};
            if (bit_q == 3'd7) st_q <= S_STOP;
            else bit_q <= bit_q + 3'd1;
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        default: begin
          if (ctr_q == BIT_LAST) begin
            new_data_q <= 1'b1;
            st_q       <= S_IDLE;
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign data     = data_q;
  assign new_data = new_data_q;
endmodule

// File: rtl/serial_tx.sv
// UART byte transmitter: 8N1, LSB first, CLK_PER_BIT clocks per bit.
// Latency: start bit begins the cycle after new_data is accepted.
// Backpressure: busy high while a byte is on the line or block is asserted.
module serial_tx #(
  parameter int CLK_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tx,
  input  logic       block,
  output logic       busy,
  input  logic [7:0] data,
  input  logic       new_data
);
  localparam int CW = $clog2(CLK_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  tx_state_t     st_q;
  logic [CW-1:0] ctr_q;
  logic [2:0]    bit_q;
  logic [7:0]    data_q;
  logic          tx_q;
  logic          busy_q;

  // Bit-timing state machine; line level is registered so tx never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= S_IDLE;
      ctr_q  <= '0;
      bit_q  <= '0;
      data_q <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      case (st_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= block;
          if (new_data && !block) begin
            data_q <= data;
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
            ctr_q  <= '0;
            st_q   <= S_START;
          end
        end
        S_START: begin
          if (ctr_q == BIT_LAST) begin
            ctr_q <= '0;
            bit_q <= '0;
            tx_q  <= data_q[0];
            st_q  <= S_DATA;
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        S_DATA: begin
          if (ctr_q == BIT_LAST) begin
            ctr_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q <= 1'b1;
              st_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= data_q[bit_q + 3'd1];
            end
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        default: begin
          if (ctr_q == BIT_LAST) begin
            ctr_q  <= '0;
            busy_q <= block;
            st_q   <= S_IDLE;
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
endmodule

// File: rtl/aes256_uart_host.sv
// Sends key+plaintext as a 48-byte UART frame, collects the 16-byte ciphertext reply.
// Latency: busy and first byte launch one cycle after start; frame ~480*CLK_PER_BIT cycles.
// Backpressure: tx bytes gated by serial_tx busy; start ignored while busy and on the done cycle.
module aes256_uart_host
  import aes_uart_pkg::*;
#(
  parameter int CLK_PER_BIT    = 87,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] key_in,
  input  logic [127:0] text_in,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [127:0] text_out,
  output logic         uart_tx,
  input  logic         uart_rx
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]      TX_LAST = 6'(NUM_BYTES_TX_FRAME - 1);
  localparam logic [4:0]      RX_LAST = 5'(NUM_RESP_BYTES - 1);

  host_state_t     state_q;
  logic [255:0]    key_q;
  logic [127:0]    text_q;
  logic [5:0]      tx_cnt_q;
  logic [4:0]      rx_cnt_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            wait_q;
  logic [127:0]    resp_q;
  logic [127:0]    resp_d;
  logic [127:0]    text_out_q;
  logic            busy_q;
  logic            done_q;
  logic            timeout_q;

  logic            eng_rst;
  logic [7:0]      tx_byte;
  logic            tx_new_data;
  logic            tx_busy;
  logic [7:0]      rx_data;
  logic            rx_new_data;

  assign eng_rst     = !reset_n;
  assign tx_new_data = (state_q == ST_SEND);

  aes_uart_byte_mux u_byte_mux (
    .key_i  (key_q),
    .text_i (text_q),
    .sel_i  (tx_cnt_q),
    .byte_o (tx_byte)
  );

  serial_tx #(.CLK_PER_BIT(CLK_PER_BIT)) u_serial_tx (
    .clk      (clk),
    .rst      (eng_rst),
    .tx       (uart_tx),
    .block    (1'b0),
    .busy     (tx_busy),
    .data     (tx_byte),
    .new_data (tx_new_data)
  );

  serial_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_serial_rx (
    .clk      (clk),
    .rst      (eng_rst),
    .rx       (uart_rx),
    .data     (rx_data),
    .new_data (rx_new_data)
  );

  // Response word with the byte currently on rx_data merged in, so the 16th byte lands in text_out.
  always_comb begin
    resp_d = resp_q;
    resp_d[8*rx_cnt_q +: 8] = rx_data;
  end

  // Transaction FSM; done/timeout are one-cycle pulses and busy drops on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      text_q     <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      to_cnt_q   <= '0;
      wait_q     <= 1'b0;
      resp_q     <= '0;
      text_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // done_q is still high in the cycle right after completion; a start there is dropped.
          if (start && !done_q) begin
            key_q    <= key_in;
            text_q   <= text_in;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            to_cnt_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_SEND;
          end
        end
        ST_SEND: begin
          wait_q  <= 1'b1;
          state_q <= ST_SEND_WAIT;
        end
        ST_SEND_WAIT: begin
          if (wait_q) begin
            wait_q <= 1'b0;
          end else if (!tx_busy) begin
            tx_cnt_q <= tx_cnt_q + 6'd1;
            state_q  <= (tx_cnt_q == TX_LAST) ? ST_RESP : ST_SEND;
          end
        end
        default: begin
          // A received byte takes priority over an expiring timeout in the same cycle.
          if (rx_new_data) begin
            resp_q   <= resp_d;
            rx_cnt_q <= rx_cnt_q + 5'd1;
            to_cnt_q <= '0;
            if (rx_cnt_q == RX_LAST) begin
              text_out_q <= resp_d;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end else if (to_cnt_q == TO_LAST) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign text_out = text_out_q;
endmodule

// File: tb/tb_aes256_uart_host.sv
// Bench for aes256_uart_host: decodes uart_tx, plays the encryptor on uart_rx.
// Latency: n/a.
// Backpressure: n/a.
module tb_aes256_uart_host;
  localparam int CPB = 8;
  localparam int TO  = 2000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] key_in = '0;
  logic [127:0] text_in = '0;
  logic         busy, done, timeout, uart_tx;
  logic [127:0] text_out;
  logic         uart_rx = 1'b1;

  int checks = 0;
  int errors = 0;

  aes256_uart_host #(.CLK_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key_in(key_in), .text_in(text_in),
    .busy(busy), .done(done), .timeout(timeout), .text_out(text_out),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Line decoder: every byte seen on uart_tx goes to txq.
  logic [7:0] txq[$];
  logic [7:0] mon_b;
  initial forever begin
    @(negedge clk);
    if (reset_n && uart_tx === 1'b0) begin
      repeat (CPB/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      txq.push_back(mon_b);
    end
  end

  // Pulse observer.
  int done_cnt = 0, to_cnt = 0, done_cyc = 0, to_cyc = 0;
  logic busy_at_done, busy_before_done, busy_at_to, busy_last = 1'b0;
  logic [127:0] text_at_done;
  always @(negedge clk) begin
    if (done) begin
      done_cnt++; done_cyc = cyc; busy_at_done = busy;
      busy_before_done = busy_last; text_at_done = text_out;
    end
    if (timeout) begin
      to_cnt++; to_cyc = cyc; busy_at_to = busy;
    end
    busy_last = busy;
  end

  // Reference model: frame is key bytes 0..31 then text bytes 0..15; reply assembles LSB-first.
  logic [7:0] exp_frame[48];
  logic [7:0] rsp[16];
  int rsp_n = 16;
  int last_rx_end = 0;

  function automatic void model_frame(input logic [255:0] k, input logic [127:0] t);
    for (int i = 0; i < 32; i++) exp_frame[i] = k[8*i +: 8];
    for (int j = 0; j < 16; j++) exp_frame[32+j] = t[8*j +: 8];
  endfunction

  function automatic logic [127:0] model_resp();
    logic [127:0] r = '0;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = rsp[j];
    return r;
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < 8; i++) key_in[32*i +: 32] = $urandom;
    for (int i = 0; i < 4; i++) text_in[32*i +: 32] = $urandom;
  endtask

  task automatic randomize_rsp();
    for (int i = 0; i < 16; i++) rsp[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
    last_rx_end = cyc;
  endtask

  task automatic send_resp();
    for (int i = 0; i < rsp_n; i++) send_byte(rsp[i]);
  endtask

  task automatic wait_frame(input int n, output bit ok, output int busy_low);
    ok = 1'b0; busy_low = 0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (txq.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pulse(input int bd, input int bt, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done_cnt > bd || to_cnt > bt) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    checks++; if (text_out !== 128'h0) begin errors++; $display("FAIL reset_text_out got %h exp 0", text_out); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx got %b exp 1", uart_tx); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Full transaction with the reference key/text and a 0x00..0x0f reply.
  task automatic test_known_frame();
    bit ok; int bl; int bd; logic [127:0] exp;
    for (int i = 0; i < 32; i++) key_in[8*i +: 8] = 8'(i);
    for (int j = 0; j < 16; j++) text_in[8*j +: 8] = 8'(j * 17);
    model_frame(key_in, text_in);
    txq.delete();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL known_busy_rise got %b exp 1", busy); end
    wait_frame(48, ok, bl);
    checks++; if (!ok) begin errors++; $display("FAIL known_frame_wait got %0d bytes exp 48", txq.size()); end
    checks++; if (bl != 0) begin errors++; $display("FAIL known_busy_held low_cycles %0d exp 0", bl); end
    for (int i = 0; i < 48; i++) begin
      checks++;
      if (txq[i] !== exp_frame[i]) begin errors++; $display("FAIL known_byte%0d got %h exp %h", i, txq[i], exp_frame[i]); end
    end
    repeat (20) @(negedge clk);
    for (int i = 0; i < 16; i++) rsp[i] = 8'(i);
    rsp_n = 16; bd = done_cnt; exp = model_resp();
    fork send_resp(); join_none
    wait_pulse(bd, to_cnt, ok);
    repeat (100) @(negedge clk);
    checks++; if (done_cnt != bd + 1) begin errors++; $display("FAIL known_done_count got %0d exp 1", done_cnt - bd); end
    checks++; if (text_at_done !== exp) begin errors++; $display("FAIL known_text_out got %h exp %h", text_at_done, exp); end
    checks++; if (busy_at_done !== 1'b0 || busy_before_done !== 1'b1) begin
      errors++; $display("FAIL known_busy_fall at_done %b before %b exp 0/1", busy_at_done, busy_before_done); end
    checks++; if (text_out !== exp) begin errors++; $display("FAIL known_text_hold got %h exp %h", text_out, exp); end
  endtask

  // Random key/text/reply, twice.
  task automatic test_random_txn();
    bit ok; int bl; int bd; logic [127:0] exp;
    for (int t = 0; t < 2; t++) begin
      randomize_inputs(); randomize_rsp();
      model_frame(key_in, text_in);
      txq.delete();
      pulse_start();
      wait_frame(48, ok, bl);
      checks++; if (!ok || bl != 0) begin errors++; $display("FAIL rand_frame ok %0d busy_low %0d exp 1/0", ok, bl); end
      for (int i = 0; i < 48; i++) begin
        checks++;
        if (txq[i] !== exp_frame[i]) begin errors++; $display("FAIL rand_byte%0d got %h exp %h", i, txq[i], exp_frame[i]); end
      end
      repeat (20) @(negedge clk);
      rsp_n = 16; bd = done_cnt; exp = model_resp();
      fork send_resp(); join_none
      wait_pulse(bd, to_cnt, ok);
      checks++; if (!ok || text_out !== exp) begin errors++; $display("FAIL rand_text_out got %h exp %h", text_out, exp); end
      repeat (40) @(negedge clk);
    end
  endtask

  // Only 5 reply bytes: timeout ~TO cycles after the 5th byte lands, text_out untouched.
  task automatic test_timeout();
    bit ok; int bl; int bd; int bt; int el; logic [127:0] prior;
    prior = text_out;
    randomize_inputs(); randomize_rsp();
    txq.delete();
    pulse_start();
    wait_frame(48, ok, bl);
    checks++; if (!ok) begin errors++; $display("FAIL to_frame_wait got %0d bytes exp 48", txq.size()); end
    repeat (20) @(negedge clk);
    rsp_n = 5; bd = done_cnt; bt = to_cnt;
    send_resp();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_after5 got %b exp 1", busy); end
    wait_pulse(bd, bt, ok);
    repeat (50) @(negedge clk);
    el = to_cyc - last_rx_end;
    checks++; if (to_cnt != bt + 1) begin errors++; $display("FAIL to_pulse_count got %0d exp 1", to_cnt - bt); end
    checks++; if (el < TO - CPB || el > TO + CPB) begin errors++; $display("FAIL to_latency got %0d exp %0d+-%0d", el, TO, CPB); end
    checks++; if (done_cnt != bd) begin errors++; $display("FAIL to_no_done got %0d exp 0", done_cnt - bd); end
    checks++; if (busy_at_to !== 1'b0) begin errors++; $display("FAIL to_busy_fall got %b exp 0", busy_at_to); end
    checks++; if (text_out !== prior) begin errors++; $display("FAIL to_text_kept got %h exp %h", text_out, prior); end
    rsp_n = 16;
  endtask

  // start held and key/text churned mid-frame: one frame carrying the first captured values.
  task automatic test_start_ignored();
    bit ok; int bl; int bd;
    randomize_inputs(); randomize_rsp();
    model_frame(key_in, text_in);
    txq.delete();
    pulse_start();
    repeat (100) @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (c % 50 == 0) randomize_inputs();
      @(negedge clk);
    end
    start = 1'b0;
    wait_frame(48, ok, bl);
    checks++; if (!ok || bl != 0) begin errors++; $display("FAIL ign_frame ok %0d busy_low %0d exp 1/0", ok, bl); end
    for (int i = 0; i < 48; i++) begin
      checks++;
      if (txq[i] !== exp_frame[i]) begin errors++; $display("FAIL ign_byte%0d got %h exp %h", i, txq[i], exp_frame[i]); end
    end
    repeat (20) @(negedge clk);
    bd = done_cnt;
    fork send_resp(); join_none
    wait_pulse(bd, to_cnt, ok);
    repeat (300) @(negedge clk);
    checks++; if (txq.size() != 48 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_no_second_frame bytes %0d busy %b exp 48/0", txq.size(), busy); end
  endtask

  // Reset during byte 20, then a clean frame from key byte 0.
  task automatic test_reset_mid_frame();
    bit ok; int bl; int bd; logic [127:0] exp;
    randomize_inputs();
    txq.delete();
    pulse_start();
    wait_frame(20, ok, bl);
    repeat (3*CPB) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || uart_tx !== 1'b1) begin
      errors++; $display("FAIL rst_mid busy %b uart_tx %b exp 0/1", busy, uart_tx); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (120) @(negedge clk);
    txq.delete();
    randomize_inputs(); randomize_rsp();
    model_frame(key_in, text_in);
    pulse_start();
    wait_frame(48, ok, bl);
    checks++; if (!ok) begin errors++; $display("FAIL rst_frame_wait got %0d bytes exp 48", txq.size()); end
    for (int i = 0; i < 48; i++) begin
      checks++;
      if (txq[i] !== exp_frame[i]) begin errors++; $display("FAIL rst_byte%0d got %h exp %h", i, txq[i], exp_frame[i]); end
    end
    repeat (20) @(negedge clk);
    bd = done_cnt; exp = model_resp();
    fork send_resp(); join_none
    wait_pulse(bd, to_cnt, ok);
    checks++; if (!ok || text_out !== exp) begin errors++; $display("FAIL rst_text_out got %h exp %h", text_out, exp); end
    repeat (40) @(negedge clk);
  endtask

  // Stray byte during SEND is dropped; reply still assembles from byte 0.
  task automatic test_rx_during_send();
    bit ok; int bl; int bd; logic [127:0] exp;
    randomize_inputs(); randomize_rsp();
    txq.delete();
    pulse_start();
    repeat (200) @(negedge clk);
    send_byte(8'hA5);
    wait_frame(48, ok, bl);
    checks++; if (!ok) begin errors++; $display("FAIL stray_frame_wait got %0d bytes exp 48", txq.size()); end
    repeat (20) @(negedge clk);
    bd = done_cnt; exp = model_resp();
    fork send_resp(); join_none
    wait_pulse(bd, to_cnt, ok);
    checks++; if (!ok || text_out !== exp) begin errors++; $display("FAIL stray_text_out got %h exp %h", text_out, exp); end
    repeat (40) @(negedge clk);
  endtask

  // start raised in the done cycle is dropped; held one more cycle it is taken.
  task automatic test_back_to_back();
    bit ok; int bl; bit seen; int bd;
    randomize_inputs(); randomize_rsp();
    txq.delete();
    pulse_start();
    wait_frame(48, ok, bl);
    repeat (20) @(negedge clk);
    fork send_resp(); join_none
    seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_done_seen got 0 exp 1"); end
    randomize_inputs();
    model_frame(key_in, text_in);
    start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done busy %b exp 0", busy); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_start_next busy %b exp 1", busy); end
    repeat (100) @(negedge clk);
    txq.delete();
    wait_frame(47, ok, bl);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_frame_wait got %0d bytes exp 47", txq.size()); end
    // The queue was cleared after the first byte started; compare the remaining 47.
    for (int i = 0; i < 47; i++) begin
      checks++;
      if (txq[i] !== exp_frame[i+1]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", i+1, txq[i], exp_frame[i+1]); end
    end
    repeat (20) @(negedge clk);
    bd = done_cnt;
    fork send_resp(); join_none
    wait_pulse(bd, to_cnt, ok);
    checks++; if (!ok || text_out !== model_resp()) begin errors++; $display("FAIL b2b_text_out got %h exp %h", text_out, model_resp()); end
  endtask

  initial begin
    test_reset();
    test_known_frame();
    test_random_txn();
    test_timeout();
    test_start_ignored();
    test_reset_mid_frame();
    test_rx_during_send();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes256_uart_host.md
# aes256_uart_host

Initiator side of the AES-256 UART link. It captures a 256-bit key and a 128-bit plaintext, serializes them as a 48-byte frame on uart_tx, then collects the 16-byte ciphertext response from uart_rx and presents it as one 128-bit word. It sits in a host/tester FPGA, or in a bench top level, facing the encryptor's UART pins. It reuses the codebase serial_tx and serial_rx byte engines.

## Interface
- CLK_PER_BIT, 87: clocks per UART bit (10 MHz / 115200); passed to serial_tx and serial_rx.
- TIMEOUT_CYCLES, 2000000: idle cycles allowed between response bytes before aborting.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request transaction; sampled only in IDLE.
- key_in  in  256  key; byte i is key_in[8i+7:8i].
- text_in  in  128  plaintext; byte j is text_in[8j+7:8j].
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse: text_out updated.
- timeout  out  1  one-cycle pulse: response aborted.
- text_out  out  128  last complete ciphertext; byte j is text_out[8j+7:8j].
- uart_tx  out  1  serial line to the encryptor (idle high).
- uart_rx  in  1  serial line from the encryptor.

## Operation
- FSM states: IDLE, SEND, SEND_WAIT, RESP.
- IDLE: when start=1, copy key_in and text_in into shadow registers, clear tx_cnt (6 bit), rx_cnt (5 bit) and the timeout counter, and go to SEND. start is ignored in every other state.
- SEND: drive the tx byte and pulse tx new_data for exactly one cycle, then go to SEND_WAIT.
  - tx_cnt 0..31 selects shadow key byte tx_cnt.
  - tx_cnt 32..47 selects shadow text byte tx_cnt-32.
- SEND_WAIT: wait one cycle, then stay until tx busy=0. Then increment tx_cnt. If tx_cnt was 47, go to RESP; otherwise go to SEND.
- RESP: on each rx new_data, write the byte to resp[8*rx_cnt +: 8], increment rx_cnt, and clear the timeout counter.
  - On the 16th byte: text_out <= assembled word (including the current byte), pulse done, go to IDLE.
- RESP timeout: the counter increments every cycle without rx new_data. When it reaches TIMEOUT_CYCLES: pulse timeout, go to IDLE, leave text_out unchanged.
- rx bytes arriving in IDLE, SEND or SEND_WAIT are discarded.
- After a timeout, the remote rx counter is left mid-frame. Recovering it by resetting the remote is the system's responsibility.
- Arithmetic:
  - counters are unsigned.
  - the timeout counter width is $clog2(TIMEOUT_CYCLES+1).
  - no wrap-around is reachable.

## Timing
- Reset values: busy=0, done=0, timeout=0, text_out=0, uart_tx=1, state=IDLE. Reset is asynchronous and takes effect mid-byte or mid-frame. serial_tx/serial_rx receive rst=!reset_n.
- start high at edge N: busy=1 from N+1; first new_data pulse at N+1.
- Consecutive tx bytes are back-to-back, gated only by serial_tx busy. A frame takes ≈48×10×CLK_PER_BIT cycles.
- done and timeout are mutually exclusive single-cycle pulses. busy falls in the same cycle as either pulse.
- text_out is stable except on the done cycle.
- Simultaneous events:
  - rx new_data in the same cycle the timeout counter would reach TIMEOUT_CYCLES: the byte wins and the counter clears.
  - start in the done cycle: ignored. The next start is accepted one cycle later.

## Structure
- Shared package aes_uart_pkg holds: NUM_BYTES_TX_FRAME=48, NUM_KEY_BYTES=32, NUM_RESP_BYTES=16, and the FSM state encoding.
- Instantiates the existing serial_tx with tx_block=0, and serial_rx.
- One optional sub-module, aes_uart_byte_mux: combinational shadow-byte select indexed by tx_cnt.

## Test plan
- key_in=256'h1f1e…0100, text_in=128'hffeeddccbbaa99887766554433221100, start pulse -> uart_tx decodes 0x00,0x01,…,0x1f,0x00,0x11,…,0xff (48 bytes, in order); busy high throughout.
- Bench responder returns 0x00..0x0f after the frame -> text_out=128'h0f0e0d0c0b0a09080706050403020100; done pulses once; busy falls the same cycle.
- TIMEOUT_CYCLES=2000; responder sends only 5 bytes -> timeout pulses 2000 cycles after the 5th byte's new_data; done never pulses; text_out keeps its prior value.
- start pulsed again during SEND, and key_in changed after start -> no second frame; transmitted bytes match the values captured at the first start.
- reset_n low during byte 20 -> busy=0 and uart_tx=1 within one cycle; after release, start gives a complete 48-byte frame beginning with key byte 0.
- Responder injects a byte during SEND -> byte discarded; response assembly still starts at text_out[7:0].
